// File: rtl/time_set_controller_pkg.sv
// Shared definitions for the alarm-clock time-set controller: mode encodings,
// counter increment weights and a width helper for parameter-sized counters.
package time_set_controller_pkg;

  typedef enum logic [1:0] {
    MODE_RUN       = 2'd0,
    MODE_SET_TIME  = 2'd1,
    MODE_SET_ALARM = 2'd2
  } mode_e;

  // Weights of each increment in 1/100 s units, as seen by the counters.
  localparam int FRACTION_WEIGHT = 1;
  localparam int MINUTE_WEIGHT   = 6000;
  localparam int HOUR_WEIGHT     = 360000;
  localparam int DAY_MAX_COUNT   = 8639999;

  // Bits needed to count 0..value-1, never less than one.
  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic mode_e next_mode_of(input mode_e cur);
    mode_e nxt;
    case (cur)
      MODE_RUN:       nxt = MODE_SET_TIME;
      MODE_SET_TIME:  nxt = MODE_SET_ALARM;
      MODE_SET_ALARM: nxt = MODE_RUN;
      default:        nxt = MODE_RUN;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/time_set_controller_if.sv
// Button levels into the controller and increment/enable/mode outputs to the
// time-of-day and alarm counters. The master side is the controller.
interface time_set_controller_if;

  logic       i_Mode_Btn;
  logic       i_Min_Btn;
  logic       i_Hr_Btn;

  logic       o_Time_Enable;
  logic       o_Time_Fraction_Inc;
  logic       o_Time_Minutes_Inc;
  logic       o_Time_Hours_Inc;
  logic       o_Alarm_Enable;
  logic       o_Alarm_Minutes_Inc;
  logic       o_Alarm_Hours_Inc;
  logic [1:0] o_Mode;
  logic       o_Set_Active;

  modport master (
    input  i_Mode_Btn,
    input  i_Min_Btn,
    input  i_Hr_Btn,
    output o_Time_Enable,
    output o_Time_Fraction_Inc,
    output o_Time_Minutes_Inc,
    output o_Time_Hours_Inc,
    output o_Alarm_Enable,
    output o_Alarm_Minutes_Inc,
    output o_Alarm_Hours_Inc,
    output o_Mode,
    output o_Set_Active
  );

  modport slave (
    output i_Mode_Btn,
    output i_Min_Btn,
    output i_Hr_Btn,
    input  o_Time_Enable,
    input  o_Time_Fraction_Inc,
    input  o_Time_Minutes_Inc,
    input  o_Time_Hours_Inc,
    input  o_Alarm_Enable,
    input  o_Alarm_Minutes_Inc,
    input  o_Alarm_Hours_Inc,
    input  o_Mode,
    input  o_Set_Active
  );

endinterface

// File: rtl/time_set_controller_button_repeater.sv
// Turns a held button level into increment pulses: one on the press, another
// after REPEAT_DELAY cycles, then one every REPEAT_PERIOD cycles until release.
module button_repeater
  import time_set_controller_pkg::*;
#(
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Btn,
  input  logic i_Clear,
  output logic o_Pulse
);

  localparam int CNT_W = clog2_min1((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic             btn_q;
  logic             lock_q;
  logic             in_period_q;
  logic [CNT_W-1:0] cnt_q;

  logic rise;
  logic held;
  logic term;

  // cnt_q counts cycles since the last pulse; term marks the cycle a repeat is due.
  always_comb begin
    rise    = i_Btn & ~btn_q;
    held    = i_Btn & btn_q;
    term    = held & (cnt_q == (in_period_q ? PERIOD_LAST : DELAY_LAST));
    o_Pulse = ~lock_q & ~i_Clear & (rise | term);
  end

  // A button held across reset or a mode change stays locked until it is released.
  always_ff @(posedge i_Clk) begin
    if (i_Reset || i_Clear) begin
      btn_q       <= i_Reset ? 1'b0 : i_Btn;
      lock_q      <= i_Btn;
      in_period_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      btn_q  <= i_Btn;
      lock_q <= lock_q & i_Btn;
      if (rise || !i_Btn) begin
        cnt_q       <= '0;
        in_period_q <= 1'b0;
      end else if (term) begin
        cnt_q       <= '0;
        in_period_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/time_set_controller.sv
// Alarm-clock sequencer: 1/100 s prescaler, RUN/SET_TIME/SET_ALARM mode machine
// with inactivity timeout, and routing of repeated minute/hour button pulses.
module time_set_controller
  import time_set_controller_pkg::*;
#(
  parameter int CLKS_PER_TICK  = 1000000,
  parameter int REPEAT_DELAY   = 50000000,
  parameter int REPEAT_PERIOD  = 10000000,
  parameter int TIMEOUT_CYCLES = 1000000000
) (
  input logic                   i_Clk,
  input logic                   i_Reset,
  time_set_controller_if.master bus
);

  localparam int PRESC_W = clog2_min1(CLKS_PER_TICK);
  localparam int IDLE_W  = clog2_min1(TIMEOUT_CYCLES);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLKS_PER_TICK - 1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT_CYCLES - 1);

  mode_e mode_q;
  mode_e mode_d;

  logic               mode_btn_q;
  logic               mode_rise;
  logic               any_btn;
  logic               timeout_hit;
  logic               mode_change;
  logic               running;
  logic [PRESC_W-1:0] presc_q;
  logic [IDLE_W-1:0]  idle_q;

  logic min_pulse;
  logic hr_pulse;

  logic frac_d;
  logic time_min_d;
  logic time_hr_d;
  logic alarm_min_d;
  logic alarm_hr_d;

  logic time_en_q;
  logic frac_q;
  logic time_min_q;
  logic time_hr_q;
  logic alarm_en_q;
  logic alarm_min_q;
  logic alarm_hr_q;
  logic set_active_q;

  // Mode next-state: a mode button edge takes priority over the idle timeout.
  always_comb begin
    mode_rise   = bus.i_Mode_Btn & ~mode_btn_q;
    any_btn     = bus.i_Mode_Btn | bus.i_Min_Btn | bus.i_Hr_Btn;
    timeout_hit = (mode_q != MODE_RUN) & ~any_btn & (idle_q == IDLE_LAST);
    mode_d      = mode_q;
    if (mode_rise) begin
      mode_d = next_mode_of(mode_q);
    end else if (timeout_hit) begin
      mode_d = MODE_RUN;
    end
    mode_change = (mode_d != mode_q);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      mode_q <= MODE_RUN;
    end else begin
      mode_q <= mode_d;
    end
  end

  // Prescaler is frozen at zero while the time is being set.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      mode_btn_q <= 1'b0;
      presc_q    <= '0;
      idle_q     <= '0;
    end else begin
      mode_btn_q <= bus.i_Mode_Btn;
      if (!running || presc_q == PRESC_LAST) begin
        presc_q <= '0;
      end else begin
        presc_q <= presc_q + PRESC_W'(1);
      end
      if (mode_change || mode_q == MODE_RUN || any_btn) begin
        idle_q <= '0;
      end else begin
        idle_q <= idle_q + IDLE_W'(1);
      end
    end
  end

  button_repeater #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_min_repeater (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_Btn   (bus.i_Min_Btn),
    .i_Clear (mode_change),
    .o_Pulse (min_pulse)
  );

  button_repeater #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_hr_repeater (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_Btn   (bus.i_Hr_Btn),
    .i_Clear (mode_change),
    .o_Pulse (hr_pulse)
  );

  // Repeater pulses go to whichever counter the current mode is setting.
  always_comb begin
    running     = (mode_q != MODE_SET_TIME);
    frac_d      = running & (presc_q == PRESC_LAST);
    time_min_d  = min_pulse & (mode_q == MODE_SET_TIME);
    time_hr_d   = hr_pulse  & (mode_q == MODE_SET_TIME);
    alarm_min_d = min_pulse & (mode_q == MODE_SET_ALARM);
    alarm_hr_d  = hr_pulse  & (mode_q == MODE_SET_ALARM);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      time_en_q    <= 1'b0;
      frac_q       <= 1'b0;
      time_min_q   <= 1'b0;
      time_hr_q    <= 1'b0;
      alarm_en_q   <= 1'b0;
      alarm_min_q  <= 1'b0;
      alarm_hr_q   <= 1'b0;
      set_active_q <= 1'b0;
    end else begin
      time_en_q    <= frac_d | time_min_d | time_hr_d;
      frac_q       <= frac_d;
      time_min_q   <= time_min_d;
      time_hr_q    <= time_hr_d;
      alarm_en_q   <= alarm_min_d | alarm_hr_d;
      alarm_min_q  <= alarm_min_d;
      alarm_hr_q   <= alarm_hr_d;
      set_active_q <= (mode_d != MODE_RUN);
    end
  end

  assign bus.o_Time_Enable       = time_en_q;
  assign bus.o_Time_Fraction_Inc = frac_q;
  assign bus.o_Time_Minutes_Inc  = time_min_q;
  assign bus.o_Time_Hours_Inc    = time_hr_q;
  assign bus.o_Alarm_Enable      = alarm_en_q;
  assign bus.o_Alarm_Minutes_Inc = alarm_min_q;
  assign bus.o_Alarm_Hours_Inc   = alarm_hr_q;
  assign bus.o_Mode              = mode_q;
  assign bus.o_Set_Active        = set_active_q;

endmodule

// File: doc/time_set_controller.md
Name: time_set_controller

Overview:
- Sequences the two time counters (time-of-day and alarm) in the alarm clock.
- Generates the 100 Hz fraction-seconds tick and the per-counter enable.
- Runs a RUN / SET_TIME / SET_ALARM mode machine from a mode button.
- Turns held minute/hour buttons into single-cycle increment pulses with auto-repeat, and times out of set modes after inactivity.

Parameters:
- CLKS_PER_TICK, 1000000, clock cycles per 1/100 s tick (100 MHz clock).
- REPEAT_DELAY, 50000000, cycles a button is held before auto-repeat starts.
- REPEAT_PERIOD, 10000000, cycles between auto-repeat pulses.
- TIMEOUT_CYCLES, 1000000000, idle cycles in a set mode before returning to RUN.

Ports:
- i_Clk  in  1  system clock
- i_Reset  in  1  synchronous, active-high reset
- i_Mode_Btn  in  1  debounced level, mode button
- i_Min_Btn  in  1  debounced level, minute button
- i_Hr_Btn  in  1  debounced level, hour button
- o_Time_Enable  out  1  enable to time-of-day counter
- o_Time_Fraction_Inc  out  1  1/100 s increment to time-of-day counter
- o_Time_Minutes_Inc  out  1  minute increment to time-of-day counter
- o_Time_Hours_Inc  out  1  hour increment to time-of-day counter
- o_Alarm_Enable  out  1  enable to alarm counter
- o_Alarm_Minutes_Inc  out  1  minute increment to alarm counter
- o_Alarm_Hours_Inc  out  1  hour increment to alarm counter
- o_Mode  out  2  0=RUN, 1=SET_TIME, 2=SET_ALARM
- o_Set_Active  out  1  high in either set mode (display blink select)

Behaviour:
- Reset: one clock, synchronous and active-high.
  - i_Reset high at a rising edge puts mode in RUN and zeroes the prescaler, repeat and timeout counters and edge registers.
  - All outputs are 0 in the following cycle.
  - Reset mid-press: a held button produces no pulse until it is released and pressed again.
- All outputs are registered. A button rising edge sampled at edge N produces its first pulse in cycle N+1, one cycle wide.
- Prescaler:
  - Counts 0..CLKS_PER_TICK-1 and wraps.
  - o_Time_Fraction_Inc pulses for one cycle when the count equals CLKS_PER_TICK-1.
  - Runs in RUN and SET_ALARM.
  - In SET_TIME it is held at 0 with no fraction pulses, so the clock is frozen while being set. Counting restarts from 0 on exit.
- Mode FSM:
  - Rising edge of i_Mode_Btn advances RUN->SET_TIME->SET_ALARM->RUN.
  - In SET_TIME or SET_ALARM, TIMEOUT_CYCLES consecutive cycles with no button high force RUN.
  - The timeout counter clears on any button level high and on every mode change.
  - If a mode edge and a timeout coincide, the mode edge wins.
- Repeaters: one per button (min, hr), independent.
  - Rising edge gives 1 pulse.
  - While held, a further pulse after REPEAT_DELAY cycles, then one every REPEAT_PERIOD cycles.
  - Release clears the repeater.
- Routing:
  - SET_TIME: minute/hour pulses drive o_Time_Minutes_Inc / o_Time_Hours_Inc.
  - SET_ALARM: minute/hour pulses drive o_Alarm_Minutes_Inc / o_Alarm_Hours_Inc.
  - RUN: minute/hour pulses are discarded.
- Simultaneous events:
  - Minute and hour pulses in the same cycle are both asserted; the counter sums them.
  - A fraction pulse coinciding with an alarm increment is allowed, since they target different counters.
- Mode change while min/hr held: both repeaters clear and are locked out until their button releases.
  - No pulse is routed in the mode-change cycle.
- Enables:
  - o_Time_Enable = OR of the three time increment outputs, registered in the same cycle.
  - o_Alarm_Enable = OR of the two alarm increment outputs.
  - Enables are never high without an increment.
- o_Set_Active = (o_Mode != 0).
- Width rule: each counter is sized by $clog2 of its parameter, minimum 1 bit. Comparisons use terminal count minus 1.

Decomposition:
- Shared package:
  - Mode encodings MODE_RUN=0, MODE_SET_TIME=1, MODE_SET_ALARM=2.
  - Increment weights FRACTION_WEIGHT=1, MINUTE_WEIGHT=6000, HOUR_WEIGHT=360000.
  - DAY_MAX_COUNT=8639999 (one day in 1/100 s).
- Sub-module button_repeater contains:
  - rising-edge detect
  - delay/period counter
  - lockout-until-release input (clear)
  - single-cycle pulse output
- Instantiated twice.

Test Plan:
- All scenarios use CLKS_PER_TICK=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, TIMEOUT_CYCLES=20.
1. Reset, RUN -> o_Time_Fraction_Inc and o_Time_Enable pulse every 4th cycle. No other outputs. o_Mode=0. Assert i_Reset mid-count -> all outputs 0 next cycle and prescaler restarts.
2. Mode edge -> o_Mode=1, fraction pulses stop. Tap i_Min_Btn 1 cycle -> exactly one o_Time_Minutes_Inc+o_Time_Enable, 1 cycle after the edge.
3. In SET_ALARM hold i_Hr_Btn 20 cycles -> o_Alarm_Hours_Inc pulses at offsets 1, 11, 14, 17, 20. Fraction ticks continue on the time outputs.
4. In SET_TIME press i_Min_Btn and i_Hr_Btn in the same cycle -> o_Time_Minutes_Inc and o_Time_Hours_Inc both high in one cycle, a single o_Time_Enable.
5. In SET_TIME hold i_Min_Btn, press mode -> o_Mode=2 with no alarm pulses while min stays held. Release, re-press -> o_Alarm_Minutes_Inc.
6. In SET_ALARM, idle 20 cycles -> o_Mode=0, o_Set_Active=0. In RUN, min/hr presses produce no increments.
